// File: rtl/seq_step_fsm.sv
// Sequence matcher: walks a latched pattern one symbol per step, with per-step
// timeout, abort, and one-cycle DONE/ERR status states.
module seq_step_fsm #(
   parameter int DW    = 4,
   parameter int STEPS = 4,
   parameter int TW    = 8,
   parameter int QW    = 8
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     valid,
   input  logic [DW-1:0]            D,
   input  logic [STEPS*DW-1:0]      pat,
   input  logic [TW-1:0]            tmo,
   output logic [QW-1:0]            Q,
   output logic [$clog2(STEPS)-1:0] step,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout
);

   localparam int SW = $clog2(STEPS);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      MATCH = 2'b01,
      DONE  = 2'b10,
      ERR   = 2'b11
   } state_t;

   state_t            state, state_nx;
   logic [SW-1:0]     step_nx;
   logic [TW-1:0]     timer, timer_nx;
   logic [QW-1:0]     q_nx;
   logic              load;
   logic              hit;
   logic [STEPS*DW-1:0] pat_r;
   logic [TW-1:0]     tmo_r;

   assign hit = valid && (D == pat_r[step*DW +: DW]);

   // Next-state logic; priority inside MATCH is abort, then match, then timeout.
   always_comb begin
      state_nx = state;
      step_nx  = step;
      timer_nx = timer;
      load     = 1'b0;
      case (state)
         IDLE: begin
            step_nx  = '0;
            timer_nx = '0;
            if (start) begin
               state_nx = MATCH;
               load     = 1'b1;
            end
         end
         MATCH: begin
            if (abort) begin
               state_nx = IDLE;
               step_nx  = '0;
               timer_nx = '0;
            end else if (hit) begin
               timer_nx = '0;
               if (step == SW'(STEPS-1)) state_nx = DONE;
               else                      step_nx  = step + 1'b1;
            end else if ((tmo_r != '0) && (timer == tmo_r)) begin
               state_nx = ERR;
            end else if (timer != '1) begin
               timer_nx = timer + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            step_nx  = '0;
            timer_nx = '0;
         end
      endcase
   end

   always_comb begin
      q_nx               = '0;
      q_nx[QW-1 -: 2]    = state_nx;
      q_nx[SW-1:0]       = step_nx;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state   <= IDLE;
         step    <= '0;
         timer   <= '0;
         Q       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nx;
         step    <= step_nx;
         timer   <= timer_nx;
         Q       <= q_nx;
         busy    <= (state_nx == MATCH);
         done    <= (state_nx == DONE);
         timeout <= (state_nx == ERR);
      end
   end

   // Pattern and limit are only sampled on acceptance of start.
   always_ff @(posedge clk) begin
      if (load) begin
         pat_r <= pat;
         tmo_r <= tmo;
      end
   end

endmodule
